// File: rtl/ttt_pkg.sv
// Shared definitions for the TTT neuron scheduler: core opcodes and the
// scheduler FSM state encoding.
package ttt_pkg;

    localparam int unsigned OP_W = 3;

    // Core instruction opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_DUR  = 3'b001;
    localparam logic [OP_W-1:0] OP_GTH  = 3'b010;
    localparam logic [OP_W-1:0] OP_BTH  = 3'b011;
    localparam logic [OP_W-1:0] OP_UPD  = 3'b100;
    localparam logic [OP_W-1:0] OP_STEP = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_STATE,
        ST_DRAIN,
        ST_PROG
    } sched_state_t;

endpackage

// File: rtl/ttt_slot_counter.sv
// Modulo-N slot counter shared by the UPDATE and STATE phases.
// Ports:
//   clock_fast, reset : clock, synchronous active-high reset
//   en                : advance one slot this cycle
//   clear             : force the count to 0 (wins over en)
//   count             : current slot id (registered)
//   wrap_c            : combinational, high when en and count is N-1
module ttt_slot_counter #(
    parameter int unsigned N = 10,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clock_fast,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap_c
);

    assign wrap_c = en && (count == W'(N - 1));

    // Count register; wraps N-1 -> 0 so it never reaches N
    always_ff @(posedge clock_fast) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Sweep scheduler for the TTT neuron core. On each slow tick it issues UPD to
// every slot, then STEP (with the slow clock enable) to every slot, then one
// drain cycle; between sweeps it forwards host programming transfers.
// Optional build macro: TTT_SCHED_OVERRUN_EN adds a sticky overrun flag.
// Ports:
//   clock_fast, reset                  : clock, synchronous active-high reset
//   tick                               : slow-time pulse requesting a sweep
//   prog_valid/prog_ready              : host programming handshake
//   prog_instr/prog_neuron/prog_data   : programming opcode, slot, value
//   core_instruction/neuron_id/prog_data, core_clock_slow : core drive
//   core_token_startstop               : registered core result
//   evt_valid/evt_neuron/evt_startstop : token event out
//   busy, sweep_done, prog_err         : status
//   overrun (macro only)               : sticky tick-overrun flag
module tt_um_jleugeri_ttt_scheduler
    import ttt_pkg::*;
#(
    parameter int unsigned NUM_PROCESSORS = 10,
    parameter int unsigned PROG_WIDTH     = 8,
    localparam int unsigned ID_W          = $clog2(NUM_PROCESSORS)
) (
    input  logic                  clock_fast,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  prog_valid,
    output logic                  prog_ready,
    input  logic [OP_W-1:0]       prog_instr,
    input  logic [ID_W-1:0]       prog_neuron,
    input  logic [PROG_WIDTH-1:0] prog_data,
    output logic [OP_W-1:0]       core_instruction,
    output logic [ID_W-1:0]       core_neuron_id,
    output logic [PROG_WIDTH-1:0] core_prog_data,
    output logic                  core_clock_slow,
    input  logic [1:0]            core_token_startstop,
    output logic                  evt_valid,
    output logic [ID_W-1:0]       evt_neuron,
    output logic [1:0]            evt_startstop,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  prog_err
`ifdef TTT_SCHED_OVERRUN_EN
    ,
    output logic                  overrun
`endif
);

    sched_state_t          state_q, state_d;
    logic                  tick_pending_q, pend_d;
    logic [OP_W-1:0]       instr_d;
    logic [ID_W-1:0]       id_d;
    logic [PROG_WIDTH-1:0] data_d;
    logic                  slow_d, done_d, busy_d, err_d;
    logic                  cnt_en, cnt_clr, wrap_c;
    logic [ID_W-1:0]       count;
    logic                  prog_legal;
    logic                  step_q;
    logic [ID_W-1:0]       step_id_q;
`ifdef TTT_SCHED_OVERRUN_EN
    logic                  ovr_d;
`endif

    ttt_slot_counter #(
        .N (NUM_PROCESSORS),
        .W (ID_W)
    ) u_slot_counter (
        .clock_fast (clock_fast),
        .reset      (reset),
        .en         (cnt_en),
        .clear      (cnt_clr),
        .count      (count),
        .wrap_c     (wrap_c)
    );

    // Handshake is combinational so a same-cycle tick can block the transfer
    assign prog_ready = (state_q == ST_IDLE) && !tick && !tick_pending_q;

    assign prog_legal = ((prog_instr == OP_DUR) || (prog_instr == OP_GTH) ||
                         (prog_instr == OP_BTH)) &&
                        (32'(prog_neuron) < NUM_PROCESSORS);

    // Next state and next registered core outputs
    always_comb begin
        state_d = state_q;
        pend_d  = tick_pending_q | tick;
        instr_d = OP_NOP;
        id_d    = '0;
        data_d  = '0;
        slow_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = prog_err;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
`ifdef TTT_SCHED_OVERRUN_EN
        ovr_d   = overrun | (tick & tick_pending_q);
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (tick || tick_pending_q) begin
                    state_d = ST_UPDATE;
                    pend_d  = 1'b0;
                    instr_d = OP_UPD;
                end else if (prog_valid) begin
                    state_d = ST_PROG;
                    if (prog_legal) begin
                        instr_d = prog_instr;
                        id_d    = prog_neuron;
                        data_d  = prog_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                cnt_en = 1'b1;
                if (wrap_c) begin
                    state_d = ST_STATE;
                    instr_d = OP_STEP;
                    slow_d  = 1'b1;
                end else begin
                    instr_d = OP_UPD;
                    id_d    = count + ID_W'(1);
                end
            end
            ST_STATE: begin
                cnt_en = 1'b1;
                if (wrap_c) begin
                    state_d = ST_DRAIN;
                    done_d  = 1'b1;
                end else begin
                    instr_d = OP_STEP;
                    slow_d  = 1'b1;
                    id_d    = count + ID_W'(1);
                end
            end
            ST_DRAIN: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            ST_PROG: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_UPDATE) || (state_d == ST_STATE) ||
                 (state_d == ST_DRAIN);
    end

    // State and registered outputs
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            tick_pending_q   <= 1'b0;
            core_instruction <= OP_NOP;
            core_neuron_id   <= '0;
            core_prog_data   <= '0;
            core_clock_slow  <= 1'b0;
            sweep_done       <= 1'b0;
            busy             <= 1'b0;
            prog_err         <= 1'b0;
        end else begin
            state_q          <= state_d;
            tick_pending_q   <= pend_d;
            core_instruction <= instr_d;
            core_neuron_id   <= id_d;
            core_prog_data   <= data_d;
            core_clock_slow  <= slow_d;
            sweep_done       <= done_d;
            busy             <= busy_d;
            prog_err         <= err_d;
        end
    end

`ifdef TTT_SCHED_OVERRUN_EN
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= ovr_d;
        end
    end
`endif

    // The core answers a STEP one cycle later; sample only then, tagged by slot
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            step_q        <= 1'b0;
            step_id_q     <= '0;
            evt_valid     <= 1'b0;
            evt_neuron    <= '0;
            evt_startstop <= '0;
        end else begin
            step_q        <= (core_instruction == OP_STEP);
            step_id_q     <= core_neuron_id;
            evt_valid     <= step_q && (core_token_startstop != 2'b00);
            evt_neuron    <= step_q ? step_id_q : '0;
            evt_startstop <= step_q ? core_token_startstop : 2'b00;
        end
    end

endmodule
